// File: rtl/cp0_exc_unit_pkg.sv
// Shared definitions for the CP0 exception unit: register numbers, exception
// codes and the SR / Cause field layout.
package cp0_exc_unit_pkg;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_SR      = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;
  localparam logic [4:0] CP0_PRID    = 5'd15;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Bit positions of the architected fields; everything else reads as 0.
  localparam int SR_IM_HI    = 15;
  localparam int SR_IM_LO    = 10;
  localparam int SR_EXL      = 1;
  localparam int SR_IE       = 0;
  localparam int CAUSE_BD    = 31;
  localparam int CAUSE_IP_HI = 15;
  localparam int CAUSE_IP_LO = 10;
  localparam int CAUSE_EX_HI = 6;
  localparam int CAUSE_EX_LO = 2;

  typedef struct packed {
    logic [5:0] im;
    logic       exl;
    logic       ie;
  } sr_t;

  function automatic logic [31:0] pack_sr(input sr_t sr);
    logic [31:0] v;
    v = '0;
    v[SR_IM_HI:SR_IM_LO] = sr.im;
    v[SR_EXL]            = sr.exl;
    v[SR_IE]             = sr.ie;
    return v;
  endfunction

  function automatic logic [31:0] pack_cause(input logic bd, input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] v;
    v = '0;
    v[CAUSE_BD]                = bd;
    v[CAUSE_IP_HI:CAUSE_IP_LO] = ip;
    v[CAUSE_EX_HI:CAUSE_EX_LO] = exc;
    return v;
  endfunction

endpackage

// File: rtl/cp0_exc_unit_timer.sv
// Count/Compare timer for CP0; only instantiated when CP0_TIMER_EN is defined.
// The timer flag is sticky until Compare is rewritten.
module cp0_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  logic ti_q;
  logic match;

  assign match = (count == compare) && (compare != 32'd0);
  // The match itself raises the line in the cycle Count reaches Compare.
  assign ti    = ti_q | match;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count   <= '0;
      compare <= '0;
      ti_q    <= 1'b0;
    end else begin
      count <= count_we ? wdata : count + 32'd1;
      if (compare_we) begin
        compare <= wdata;
        ti_q    <= 1'b0;
      end else if (match) begin
        ti_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 exception/interrupt unit: SR, Cause, EPC, PRId plus mfc0/mtc0/eret.
// Optional Count/Compare timer on HWInt[7] is enabled with CP0_TIMER_EN.
module cp0_exc_unit
  import cp0_exc_unit_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h1802_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        WE,
  input  logic [31:0] PC,
  input  logic        BD,
  input  logic [6:2]  ExcCode,
  input  logic [7:2]  HWInt,
  input  logic        EXLClr,
  output logic        ExcReq,
  output logic [31:0] EPC_out,
  output logic [31:0] DOut
);

  sr_t         sr_q;
  logic        cause_bd_q;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_exc_q;
  logic [31:0] epc_q;

  logic [7:2]  hw_eff;
  logic        int_req;
  logic        syn_req;
  logic        mtc0_we;

  // An exception cycle swallows any mtc0 issued alongside it.
  assign mtc0_we = WE & ~ExcReq;

`ifdef CP0_TIMER_EN
  logic [31:0] count_val;
  logic [31:0] compare_val;
  logic        ti;

  cp0_timer u_timer (
    .clk        (clk),
    .reset      (reset),
    .count_we   (mtc0_we && (A2 == CP0_COUNT)),
    .compare_we (mtc0_we && (A2 == CP0_COMPARE)),
    .wdata      (DIn),
    .count      (count_val),
    .compare    (compare_val),
    .ti         (ti)
  );

  assign hw_eff = {HWInt[7] | ti, HWInt[6:2]};
`else
  assign hw_eff = HWInt;
`endif

  assign int_req = (|(hw_eff & sr_q.im)) & sr_q.ie & ~sr_q.exl;
  assign syn_req = (ExcCode != EXC_INT) & ~sr_q.exl;
  assign ExcReq  = int_req | syn_req;
  assign EPC_out = epc_q;

  // NOTE: non-blocking assignments so every field updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sr_q        <= '0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= '0;
      cause_exc_q <= '0;
      epc_q       <= '0;
    end else begin
      cause_ip_q <= hw_eff;
      if (ExcReq) begin
        sr_q.exl    <= 1'b1;
        cause_exc_q <= int_req ? EXC_INT : ExcCode;
        cause_bd_q  <= BD;
        epc_q       <= (BD ? PC - 32'd4 : PC) & ~32'd3;
      end else begin
        if (WE && (A2 == CP0_SR)) begin
          sr_q.im  <= DIn[SR_IM_HI:SR_IM_LO];
          sr_q.exl <= DIn[SR_EXL];
          sr_q.ie  <= DIn[SR_IE];
        end
        if (WE && (A2 == CP0_EPC))
          epc_q <= {DIn[31:2], 2'b00};
        // eret overrides the EXL bit of a simultaneous SR write.
        if (EXLClr)
          sr_q.exl <= 1'b0;
      end
    end
  end

  // NOTE: DOut gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    DOut = '0;
    case (A1)
      CP0_SR:      DOut = pack_sr(sr_q);
      CP0_CAUSE:   DOut = pack_cause(cause_bd_q, cause_ip_q, cause_exc_q);
      CP0_EPC:     DOut = epc_q;
      CP0_PRID:    DOut = PRID;
`ifdef CP0_TIMER_EN
      CP0_COUNT:   DOut = count_val;
      CP0_COMPARE: DOut = compare_val;
`endif
      default:     DOut = '0;
    endcase
  end

endmodule
